// File: rtl/neuron_node_seq.sv
// neuron_node_seq: sequential fully-connected neuron.
// Streams LANES-wide pixel/weight beats, accumulates exact signed products
// onto a sign-extended bias with saturation, then applies a selectable
// activation and offers one OUT_W result over a valid/ready handshake.
module neuron_node_seq #(
  parameter int DATA_W = 8,
  parameter int LANES  = 16,
  parameter int BEATS  = 49,
  parameter int BIAS_W = 20,
  parameter int ACC_W  = 26,
  parameter int SHIFT  = 8,
  parameter int OUT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIAS_W-1:0]         bias,
  input  logic [1:0]                act_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   p_in,
  input  logic [LANES*DATA_W-1:0]   w_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      busy,
  output logic                      ovf
);

  // Working widths: WIDE holds bias, accumulator and a full beat sum plus
  // one bit of headroom, so acc + beat_sum can never wrap before clamping.
  localparam int PROD_W = 2 * DATA_W + 1;
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int MAX1_W = (ACC_W > SUM_W) ? ACC_W : SUM_W;
  localparam int WIDE   = ((MAX1_W > BIAS_W) ? MAX1_W : BIAS_W) + 1;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int AW2    = ACC_W + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] ACT  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Accumulator limits, both at accumulator width and at working width.
  localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [WIDE-1:0]  ACC_MAX_W = {{(WIDE-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0]  ACC_MIN_W = {{(WIDE-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  // Activation thresholds at the widened shifted-accumulator width.
  localparam logic signed [AW2-1:0] ZERO_X = {AW2{1'b0}};
  localparam logic signed [AW2-1:0] UMAX_X = {{(AW2-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [AW2-1:0] HALF_X = {{(AW2-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [AW2-1:0] SMAX_X = {{(AW2-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW2-1:0] SMIN_X = {{(AW2-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp a working-width value into the accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_val(input logic signed [WIDE-1:0] x);
    logic signed [ACC_W-1:0] r;
    if (x > ACC_MAX_W) begin
      r = ACC_MAX;
    end else if (x < ACC_MIN_W) begin
      r = ACC_MIN;
    end else begin
      r = x[ACC_W-1:0];
    end
    return r;
  endfunction

  // True when sat_val would have to clamp.
  function automatic logic sat_hit(input logic signed [WIDE-1:0] x);
    return (x > ACC_MAX_W) || (x < ACC_MIN_W);
  endfunction

  // Shift the accumulator down and map it through the selected activation.
  function automatic logic [OUT_W-1:0] activate(input logic [1:0] mode,
                                                input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    logic signed [AW2-1:0]   sx;
    logic signed [AW2-1:0]   hx;
    logic [OUT_W-1:0]        r;
    s  = a >>> SHIFT;
    sx = {{2{s[ACC_W-1]}}, s};
    hx = sx + HALF_X;
    case (mode)
      2'b01: begin
        if (hx < ZERO_X) begin
          r = {OUT_W{1'b0}};
        end else if (hx > UMAX_X) begin
          r = {OUT_W{1'b1}};
        end else begin
          r = hx[OUT_W-1:0];
        end
      end
      2'b10: begin
        if (sx < SMIN_X) begin
          r = {1'b1, {(OUT_W-1){1'b0}}};
        end else if (sx > SMAX_X) begin
          r = {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
          r = sx[OUT_W-1:0];
        end
      end
      default: begin
        // ReLU; mode 11 deliberately shares this path.
        if (sx < ZERO_X) begin
          r = {OUT_W{1'b0}};
        end else if (sx > UMAX_X) begin
          r = {OUT_W{1'b1}};
        end else begin
          r = sx[OUT_W-1:0];
        end
      end
    endcase
    return r;
  endfunction

  logic [1:0]              state_r;
  logic [1:0]              state_nxt_s;
  logic signed [ACC_W-1:0] acc_r;
  logic [1:0]              mode_r;
  logic [CNT_W-1:0]        beat_cnt_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [OUT_W-1:0]        out_data_r;
  logic                    busy_r;
  logic                    ovf_r;

  logic                    beat_acc_s;
  logic signed [WIDE-1:0]  p_ext_s;
  logic signed [WIDE-1:0]  w_ext_s;
  logic signed [WIDE-1:0]  beat_sum_s;
  logic signed [WIDE-1:0]  acc_ext_s;
  logic signed [WIDE-1:0]  sum_s;
  logic signed [WIDE-1:0]  bias_ext_s;

  assign beat_acc_s = in_valid && in_ready_r;
  assign acc_ext_s  = {{(WIDE-ACC_W){acc_r[ACC_W-1]}}, acc_r};
  assign bias_ext_s = {{(WIDE-BIAS_W){bias[BIAS_W-1]}}, bias};
  assign sum_s      = acc_ext_s + beat_sum_s;

  // Exact beat sum: zero-extended pixels times sign-extended weights.
  always_comb begin
    beat_sum_s = {WIDE{1'b0}};
    p_ext_s    = {WIDE{1'b0}};
    w_ext_s    = {WIDE{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      p_ext_s    = {{(WIDE-DATA_W){1'b0}}, p_in[i*DATA_W +: DATA_W]};
      w_ext_s    = {{(WIDE-DATA_W){w_in[i*DATA_W+DATA_W-1]}}, w_in[i*DATA_W +: DATA_W]};
      beat_sum_s = beat_sum_s + p_ext_s * w_ext_s;
    end
  end

  // Next-state decode for the IDLE/ACC/ACT/HOLD sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = ACC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC: begin
        if (beat_acc_s && (beat_cnt_r == CNT_LAST)) begin
          state_nxt_s = ACT;
        end else begin
          state_nxt_s = ACC;
        end
      end
      ACT: begin
        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == ACC);
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  // Datapath: bias load, saturating accumulation, activation and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= {ACC_W{1'b0}};
      mode_r      <= 2'b00;
      beat_cnt_r  <= CNT_ZERO;
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r      <= sat_val(bias_ext_s);
            mode_r     <= act_mode;
            beat_cnt_r <= CNT_ZERO;
            ovf_r      <= 1'b0;
          end
        end
        ACC: begin
          if (beat_acc_s) begin
            acc_r      <= sat_val(sum_s);
            ovf_r      <= ovf_r | sat_hit(sum_s);
            beat_cnt_r <= beat_cnt_r + CNT_ONE;
          end
        end
        ACT: begin
          out_data_r  <= activate(mode_r, acc_r);
          out_valid_r <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;
  assign ovf       = ovf_r;

endmodule

// File: doc/neuron_node_seq.md
Name: neuron_node_seq

Overview:
- Sequential, parametrised fully-connected neuron for the MNIST inference datapath.
- Consumes one neuron's pixel/weight vector as a stream of LANES-wide beats and accumulates signed products onto a correctly sign-extended bias.
- Applies a run-time selectable activation and presents one OUT_W result per neuron over a valid/ready handshake.
- Successor to the single-shot 16-lane node: adds depth (BEATS), flow control, saturation, overflow flag and activation modes.

Parameters:
- DATA_W, 8: pixel and weight width.
- LANES, 16: products summed per beat.
- BEATS, 49: beats per neuron (49 x 16 = 784 inputs).
- BIAS_W, 20: bias width, signed.
- ACC_W, 26: accumulator width, signed.
- SHIFT, 8: arithmetic right shift applied to the accumulator before activation.
- OUT_W, 8: result width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new neuron; honoured in IDLE only.
- bias  in  BIAS_W  signed bias, sampled on an accepted start.
- act_mode  in  2  activation select, sampled on an accepted start.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid and in_ready are both high.
- p_in  in  LANES*DATA_W  unsigned pixels; lane i occupies bits [i*DATA_W +: DATA_W].
- w_in  in  LANES*DATA_W  signed two's-complement weights; same packing as p_in.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid and out_ready are both high.
- out_data  out  OUT_W  activated result.
- busy  out  1  high in every state except IDLE.
- ovf  out  1  sticky: accumulator saturated during the current neuron.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, ovf=0; FSM in IDLE; accumulator and beat counter cleared.
- Reset asserted mid-operation aborts the neuron; no out_valid is produced.
- FSM states: IDLE, ACC, ACT, HOLD.
- IDLE -> ACC on start:
  - acc = bias sign-extended from bit BIAS_W-1 to ACC_W.
  - act_mode latched; beat_cnt = 0; ovf cleared.
- ACC: in_ready=1. On each accepted beat:
  - beat_sum = sum over lanes of zero-extended p times signed w (exact, ACC_W wide).
  - acc = sat(acc + beat_sum), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets ovf.
  - beat_cnt increments. The accepted beat with beat_cnt == BEATS-1 moves the FSM to ACT.
- ACC with in_valid low: hold all state; stall duration is unbounded.
- ACT (one cycle, in_ready=0): s = acc >>> SHIFT (arithmetic). out_data is registered as:
  - 00 ReLU: s<0 -> 0; else min(s, 2^OUT_W-1).
  - 01 hard sigmoid: clamp(s + 2^(OUT_W-1), 0, 2^OUT_W-1).
  - 10 signed linear: clamp(s, -2^(OUT_W-1), 2^(OUT_W-1)-1), two's complement.
  - 11: treated as 00.
  - FSM moves to HOLD; out_valid=1.
- HOLD: out_data and out_valid are stable until out_ready. On the handshake: out_valid=0, go to IDLE. busy drops the same edge.
- Latency: last beat accepted at edge k -> out_valid high after edge k+1.
- start outside IDLE is ignored. start and in_valid in the same IDLE cycle: the beat is not accepted (in_ready=0 in IDLE).
- ovf holds through HOLD and IDLE until the next accepted start or reset.
- Beat adder tree is combinational into the accumulator register; one beat per clock at full throughput.

Test Plan:
- Nominal (BEATS=4, SHIFT=4), all p=1, w=1, bias=0 -> acc=64; mode00 out=4, mode01 out=132, mode10 out=4; ovf=0.
- Negative (BEATS=4, SHIFT=4), p=255, w=8'hFF (-1), bias=0 -> acc=-16320; mode00 out=0, mode01 out=0, mode10 out=8'h80.
- Bias sign extension (BEATS=4, SHIFT=4), p=1, w=1:
  - bias=20'h00080 -> acc=192, mode00 out=12.
  - bias=20'hFFFC0 (-64) -> acc=0, mode01 out=128.
- Handshake: in_valid toggles every other cycle and out_ready is held low 5 cycles after out_valid -> exactly BEATS beats consumed, out_data constant while held, start pulsed during HOLD ignored, busy falls on the out handshake.
- Overflow (ACC_W=16, BEATS=4, SHIFT=4), p=255, w=127 -> acc clamps at 32767, ovf=1, mode00 out=255; next start clears ovf.
- Reset after 2 of 4 beats -> all outputs 0 immediately (asynchronous), no out_valid; a following nominal run returns 4.
